nios_ii_csum_accumulator: RTL and testbench

NIOS_II_CSUM_ACCUMULATOR -- requirements
Module: nios_ii_csum_accumulator

---
 rtl/nios_ii_csum_pkg.sv | 18 +
 rtl/nios_ii_oc_add16.sv | 14 +
 rtl/nios_ii_csum_accumulator.sv | 123 ++++++++++++
 tb/tb_nios_ii_csum_accumulator.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_ii_csum_pkg.sv
// Shared opcodes and FSM state type for the Nios II ones'-complement checksum
// custom instruction.
package nios_ii_csum_pkg;

    localparam logic [2:0] OP_CLEAR    = 3'd0;
    localparam logic [2:0] OP_ACC32    = 3'd1;
    localparam logic [2:0] OP_ACC_TAIL = 3'd2;
    localparam logic [2:0] OP_FINALIZE = 3'd3;
    localparam logic [2:0] OP_READ     = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD0 = 2'd1,
        ADD1 = 2'd2,
        DONE = 2'd3
    } csum_state_e;

endpackage

// File: rtl/nios_ii_oc_add16.sv
// 16-bit ones'-complement adder with end-around carry. Folding the carry back
// in once is enough: a 17-bit sum of two 16-bit values cannot carry twice.
module nios_ii_oc_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    logic [16:0] raw_sum;

    assign raw_sum = {1'b0, a} + {1'b0, b};
    assign sum     = raw_sum[15:0] + {15'b0, raw_sum[16]};

endmodule

// File: rtl/nios_ii_csum_accumulator.sv
// Nios II multi-cycle custom instruction accumulating an Internet-style
// ones'-complement checksum over little-endian memory words.
module nios_ii_csum_accumulator
    import nios_ii_csum_pkg::*;
(
    input  logic        ncs_clk,
    input  logic        ncs_reset_n,
    input  logic        ncs_clk_en,
    input  logic        ncs_start,
    input  logic [2:0]  ncs_n,
    input  logic [31:0] ncs_dataa,
    input  logic [31:0] ncs_datab,
    output logic        ncs_done,
    output logic [31:0] ncs_result
);

    csum_state_e state_reg, state_next;
    logic [2:0]  op_reg, op_next;
    logic [31:0] data_reg, data_next;
    logic [15:0] acc_reg, acc_next;
    logic [31:0] result_reg, result_next;

    logic [1:0][15:0] half_word;
    logic [15:0]      tail_word;
    logic [15:0]      add_operand;
    logic [15:0]      add_sum;
    logic             datab_unused;

    assign datab_unused = ^ncs_datab;

    // Memory bytes are little-endian; the checksum works on network-order halfwords.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane_swap
            assign half_word[gi] = {data_reg[16*gi +: 8], data_reg[16*gi+8 +: 8]};
        end
    endgenerate

    assign tail_word = {data_reg[7:0], 8'h00};

    always_comb begin
        add_operand = half_word[0];
        if (state_reg == ADD1) begin
            add_operand = (op_reg == OP_ACC_TAIL) ? tail_word : half_word[1];
        end
    end

    nios_ii_oc_add16 u_add (
        .a   (acc_reg),
        .b   (add_operand),
        .sum (add_sum)
    );

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        data_next   = data_reg;
        acc_next    = acc_reg;
        result_next = result_reg;

        case (state_reg)
            IDLE: begin
                if (ncs_start) begin
                    op_next   = ncs_n;
                    data_next = ncs_dataa;
                    case (ncs_n)
                        OP_ACC32:    state_next = ADD0;
                        OP_ACC_TAIL: state_next = ADD1;
                        OP_CLEAR: begin
                            acc_next    = 16'h0000;
                            result_next = 32'h0000_0000;
                            state_next  = DONE;
                        end
                        OP_FINALIZE: begin
                            result_next = {16'h0000, ~acc_reg};
                            state_next  = DONE;
                        end
                        default: begin
                            // READ and the reserved opcodes 5-7
                            result_next = {16'h0000, acc_reg};
                            state_next  = DONE;
                        end
                    endcase
                end
            end
            ADD0: begin
                acc_next   = add_sum;
                state_next = ADD1;
            end
            ADD1: begin
                acc_next    = add_sum;
                result_next = {16'h0000, add_sum};
                state_next  = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset wins over clk_en; otherwise clk_en low freezes every register.
    always_ff @(posedge ncs_clk) begin
        if (!ncs_reset_n) begin
            state_reg  <= IDLE;
            op_reg     <= OP_CLEAR;
            data_reg   <= 32'h0000_0000;
            acc_reg    <= 16'h0000;
            result_reg <= 32'h0000_0000;
        end else if (ncs_clk_en) begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            data_reg   <= data_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
        end
    end

    assign ncs_done   = (state_reg == DONE);
    assign ncs_result = result_reg;

endmodule

// File: tb/tb_nios_ii_csum_accumulator.sv
// Scoreboard bench for the checksum custom instruction: the driver pushes
// model results, a negedge monitor pops and compares on every enabled done.
module tb_nios_ii_csum_accumulator;

    logic        ncs_clk = 1'b0;
    logic        ncs_reset_n = 1'b0;
    logic        ncs_clk_en = 1'b0;
    logic        ncs_start = 1'b0;
    logic [2:0]  ncs_n = 3'd0;
    logic [31:0] ncs_dataa = 32'h0;
    logic [31:0] ncs_datab = 32'h0;
    logic        ncs_done;
    logic [31:0] ncs_result;

    nios_ii_csum_accumulator dut (
        .ncs_clk     (ncs_clk),
        .ncs_reset_n (ncs_reset_n),
        .ncs_clk_en  (ncs_clk_en),
        .ncs_start   (ncs_start),
        .ncs_n       (ncs_n),
        .ncs_dataa   (ncs_dataa),
        .ncs_datab   (ncs_datab),
        .ncs_done    (ncs_done),
        .ncs_result  (ncs_result)
    );

    always #5 ncs_clk = ~ncs_clk;

    typedef struct {
        logic [31:0] res;
        int          edge_no;
        int          op;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    bit          reset_edge = 1'b0;
    logic [31:0] hold_val = 32'h0;
    logic [15:0] acc_model = 16'h0;

    always @(posedge ncs_clk) begin
        edge_cnt++;
        reset_edge = !ncs_reset_n;
    end

    // Monitor
    always @(negedge ncs_clk) begin
        if (reset_edge) begin
            hold_val = 32'h0;
            checks++;
            if (ncs_done !== 1'b0 || ncs_result !== 32'h0) begin
                errors++;
                $display("FAIL reset_state: done=%b result=%h, required done=0 result=00000000",
                         ncs_done, ncs_result);
            end
        end
        if (ncs_done === 1'b1 && ncs_clk_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: edge=%0d result=%h, required no done pulse",
                         edge_cnt, ncs_result);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (ncs_result !== mon_e.res) begin
                    errors++;
                    $display("FAIL result op=%0d: got %h, required %h", mon_e.op, ncs_result, mon_e.res);
                end else begin
                    $display("op=%0d result=%h at edge %0d", mon_e.op, ncs_result, edge_cnt);
                end
                checks++;
                if (edge_cnt != mon_e.edge_no) begin
                    errors++;
                    $display("FAIL latency op=%0d: done at edge %0d, required edge %0d",
                             mon_e.op, edge_cnt, mon_e.edge_no);
                end
                hold_val = mon_e.res;
            end
        end else if (ncs_done !== 1'b1) begin
            checks++;
            if (ncs_result !== hold_val) begin
                errors++;
                $display("FAIL result_hold: got %h, required %h", ncs_result, hold_val);
            end
        end
    end

    // Ones'-complement addition as arithmetic modulo 0xFFFF (keeping 0xFFFF as a value).
    function automatic logic [15:0] oc_sum(input logic [15:0] a, input logic [15:0] b);
        int t;
        t = int'(a) + int'(b);
        if (t > 65535) t = t - 65535;
        return t[15:0];
    endfunction

    // stall_mode: 0 none, 1 random clk_en gaps, 2 three disabled edges in ADD0.
    task automatic run_op(input logic [2:0] op, input logic [31:0] data,
                          input int stall_mode, input bit extra_start);
        int          lat;
        int          cnt;
        int          s;
        bit          en;
        bit          p[$];
        logic [31:0] res;
        exp_t        e;
        int          b0, b1, b2, b3;
        b0 = int'(data[7:0]);
        b1 = int'(data[15:8]);
        b2 = int'(data[23:16]);
        b3 = int'(data[31:24]);
        case (op)
            3'd0: begin acc_model = 16'h0; res = 32'h0; lat = 1; end
            3'd1: begin
                acc_model = oc_sum(acc_model, 16'(b0 * 256 + b1));
                acc_model = oc_sum(acc_model, 16'(b2 * 256 + b3));
                res = {16'h0, acc_model};
                lat = 3;
            end
            3'd2: begin
                acc_model = oc_sum(acc_model, 16'(b0 * 256));
                res = {16'h0, acc_model};
                lat = 2;
            end
            3'd3: begin res = {16'h0, 16'hFFFF - acc_model}; lat = 1; end
            default: begin res = {16'h0, acc_model}; lat = 1; end
        endcase
        cnt = 1;
        if (stall_mode == 2) repeat (3) p.push_back(1'b0);
        while (cnt < lat) begin
            en = (stall_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            p.push_back(en);
            if (en) cnt++;
        end
        if (stall_mode == 1) while ($urandom_range(0, 3) == 0) p.push_back(1'b0);
        p.push_back(1'b1);
        s = edge_cnt + 1;
        e.res = res;
        e.edge_no = s + p.size() - 1;
        e.op = int'(op);
        sb.push_back(e);
        ncs_start = 1'b1;
        ncs_n = op;
        ncs_dataa = data;
        ncs_datab = $urandom;
        ncs_clk_en = 1'b1;
        @(posedge ncs_clk); #1;
        ncs_start = extra_start;
        if (extra_start) begin
            ncs_n = 3'($urandom_range(0, 7));
            ncs_dataa = $urandom;
        end
        foreach (p[i]) begin
            ncs_clk_en = p[i];
            @(posedge ncs_clk); #1;
            ncs_start = 1'b0;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_done op=%0d: %0d results outstanding, required 0", op, sb.size());
            sb.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            ncs_clk_en = 1'($urandom_range(0, 1));
            ncs_start = 1'b0;
            @(posedge ncs_clk); #1;
        end
        ncs_clk_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] op;
        int r;
        // Reset with clk_en low, then start on the very first edge after release
        ncs_reset_n = 1'b0;
        ncs_clk_en = 1'b0;
        repeat (3) @(posedge ncs_clk);
        #1;
        ncs_reset_n = 1'b1;
        run_op(3'd0, 32'h0, 0, 1'b0);
        run_op(3'd1, 32'h03F20100, 0, 1'b0);
        run_op(3'd1, 32'hF7F6F5F4, 0, 1'b0);
        run_op(3'd3, 32'h0, 0, 1'b0);

        // End-around carry cases with acc = 0xFFFF
        run_op(3'd0, 32'h0, 0, 1'b0);
        run_op(3'd1, 32'h0000FFFF, 0, 1'b0);
        run_op(3'd2, 32'h00000001, 0, 1'b0);
        run_op(3'd4, 32'h0, 0, 1'b0);
        run_op(3'd0, 32'h0, 0, 1'b0);
        run_op(3'd1, 32'h0000FFFF, 0, 1'b0);
        run_op(3'd1, 32'h00000100, 0, 1'b0);
        run_op(3'd4, 32'h0, 0, 1'b0);

        // Odd-length tail, then clk_en stall inside ADD0
        run_op(3'd0, 32'h0, 0, 1'b0);
        run_op(3'd2, 32'h000000AB, 0, 1'b0);
        run_op(3'd4, 32'h0, 0, 1'b0);
        run_op(3'd1, 32'h1234ABCD, 2, 1'b0);
        run_op(3'd4, 32'h0, 0, 1'b0);

        // Reset during ADD1 aborts with no done pulse
        ncs_start = 1'b1;
        ncs_n = 3'd1;
        ncs_dataa = 32'h12345678;
        ncs_clk_en = 1'b1;
        @(posedge ncs_clk); #1;
        ncs_start = 1'b0;
        @(posedge ncs_clk); #1;
        ncs_reset_n = 1'b0;
        @(posedge ncs_clk); #1;
        ncs_reset_n = 1'b1;
        acc_model = 16'h0;
        idle(3);
        run_op(3'd4, 32'h0, 0, 1'b0);

        // Second start during ADD0 is ignored
        run_op(3'd0, 32'h0, 0, 1'b0);
        run_op(3'd1, 32'hA5A55A5A, 0, 1'b1);
        run_op(3'd4, 32'h0, 0, 1'b0);

        // start with clk_en low is ignored
        ncs_start = 1'b1;
        ncs_n = 3'd1;
        ncs_dataa = 32'hDEADBEEF;
        ncs_clk_en = 1'b0;
        repeat (3) @(posedge ncs_clk);
        #1;
        ncs_start = 1'b0;
        ncs_clk_en = 1'b1;
        run_op(3'd4, 32'h0, 0, 1'b0);

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      op = 3'd0;
            else if (r <= 4) op = 3'd1;
            else if (r <= 6) op = 3'd2;
            else if (r == 7) op = 3'd3;
            else if (r == 8) op = 3'd4;
            else             op = 3'($urandom_range(5, 7));
            run_op(op, $urandom, $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
